// File: rtl/nasti_stream_pkg.sv
// nasti_stream_pkg
// Shared helpers for NASTI-Stream buffering blocks. A stored entry is the
// concatenation {data, strb, keep, last, id, dest, user}, with user in the
// least-significant bits. The functions below return the total entry width
// and the bit offset of each field within an entry. Both the pack and the
// unpack logic use them, so the two cannot drift apart.
package nasti_stream_pkg;

  function automatic int entry_width(input int data_w, input int id_w,
                                     input int dest_w, input int user_w);
    return data_w + 2 * (data_w / 8) + 1 + id_w + dest_w + user_w;
  endfunction

  function automatic int off_dest(input int user_w);
    return user_w;
  endfunction

  function automatic int off_id(input int dest_w, input int user_w);
    return dest_w + user_w;
  endfunction

  function automatic int off_last(input int id_w, input int dest_w, input int user_w);
    return id_w + dest_w + user_w;
  endfunction

  function automatic int off_keep(input int id_w, input int dest_w, input int user_w);
    return off_last(id_w, dest_w, user_w) + 1;
  endfunction

  function automatic int off_strb(input int data_w, input int id_w,
                                  input int dest_w, input int user_w);
    return off_keep(id_w, dest_w, user_w) + data_w / 8;
  endfunction

  function automatic int off_data(input int data_w, input int id_w,
                                  input int dest_w, input int user_w);
    return off_strb(data_w, id_w, dest_w, user_w) + data_w / 8;
  endfunction

endpackage

// File: rtl/nasti_stream_channel.sv
// nasti_stream_channel
// One NASTI-Stream channel, carrying a valid/ready handshake plus its payload.
//   master modport : drives t_valid and the payload, samples t_ready
//   slave modport  : samples t_valid and the payload, drives t_ready
interface nasti_stream_channel #(
  parameter int ID_WIDTH   = 1,
  parameter int DEST_WIDTH = 1,
  parameter int USER_WIDTH = 1,
  parameter int DATA_WIDTH = 8
);
  logic                      t_valid;
  logic                      t_ready;
  logic [DATA_WIDTH-1:0]     t_data;
  logic [DATA_WIDTH/8-1:0]   t_strb;
  logic [DATA_WIDTH/8-1:0]   t_keep;
  logic                      t_last;
  logic [ID_WIDTH-1:0]       t_id;
  logic [DEST_WIDTH-1:0]     t_dest;
  logic [USER_WIDTH-1:0]     t_user;

  modport master (
    output t_valid, t_data, t_strb, t_keep, t_last, t_id, t_dest, t_user,
    input  t_ready
  );

  modport slave (
    input  t_valid, t_data, t_strb, t_keep, t_last, t_id, t_dest, t_user,
    output t_ready
  );
endinterface

// File: rtl/nasti_stream_fifo_mem.sv
// nasti_stream_fifo_mem
// DEPTH x EW storage array. It has one synchronous write port and one
// asynchronous read port. The contents are deliberately not reset.
//   clk_i   : clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address
//   rdata_o : read data (combinational from raddr_i)
module nasti_stream_fifo_mem #(
  parameter int EW    = 8,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [EW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [EW-1:0] rdata_o
);

  logic [EW-1:0] mem_q [DEPTH];

  // Write port: store the entry on an accepted beat.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/nasti_stream_fifo.sv
// nasti_stream_fifo
// Synchronous FIFO for a single NASTI-Stream channel. Beats accepted on s are
// re-issued unchanged on m, with every sideband field carried alongside the
// data. The output is fall-through, read straight from storage, but a beat
// accepted at edge N becomes visible on m only after that edge. There is no
// combinational path from s to m.
// Ports:
//   clk   : clock
//   rstn  : asynchronous active-low reset; discards stored beats
//   s     : upstream channel (slave modport)
//   m     : downstream channel (master modport)
//   count : number of stored entries
// Optional macro NASTI_STREAM_FIFO_PACKET_MODE_EN enables store-and-forward.
// In that mode m.t_valid is withheld until a complete packet (one with
// t_last) is stored. A completely full FIFO also releases m.t_valid, so
// packets longer than DEPTH cannot deadlock.
module nasti_stream_fifo
  import nasti_stream_pkg::*;
#(
  parameter int ID_WIDTH   = 1,
  parameter int DEST_WIDTH = 1,
  parameter int USER_WIDTH = 1,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  nasti_stream_channel.slave         s,
  nasti_stream_channel.master        m,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW       = $clog2(DEPTH);
  localparam int PW       = AW + 1;
  localparam int SW       = DATA_WIDTH / 8;
  localparam int EW       = entry_width(DATA_WIDTH, ID_WIDTH, DEST_WIDTH, USER_WIDTH);
  localparam int OFF_DEST = off_dest(USER_WIDTH);
  localparam int OFF_ID   = off_id(DEST_WIDTH, USER_WIDTH);
  localparam int OFF_LAST = off_last(ID_WIDTH, DEST_WIDTH, USER_WIDTH);
  localparam int OFF_KEEP = off_keep(ID_WIDTH, DEST_WIDTH, USER_WIDTH);
  localparam int OFF_STRB = off_strb(DATA_WIDTH, ID_WIDTH, DEST_WIDTH, USER_WIDTH);
  localparam int OFF_DATA = off_data(DATA_WIDTH, ID_WIDTH, DEST_WIDTH, USER_WIDTH);

  logic          push_s;
  logic          pop_s;
  logic          full_s;
  logic          empty_s;
  logic [EW-1:0] wr_entry_s;
  logic [EW-1:0] rd_entry_s;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] count_q, count_d;
  logic          s_ready_q, s_ready_d;
  logic          m_valid_q, m_valid_d;

`ifdef NASTI_STREAM_FIFO_PACKET_MODE_EN
  logic [PW-1:0] pkt_cnt_q, pkt_cnt_d;
`endif

  // Handshakes use the registered ready/valid that are presented on the ports.
  assign push_s = s.t_valid & s_ready_q;
  assign pop_s  = m_valid_q & m.t_ready;

  // Next pointer values; the extra MSB wraps naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PW'(1'b1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1'b1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

`ifdef NASTI_STREAM_FIFO_PACKET_MODE_EN
  // Complete-packet counter: +1 on a stored last beat, -1 on a popped last beat.
  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    case ({push_s & s.t_last, pop_s & m.t_last})
      2'b10:   pkt_cnt_d = pkt_cnt_q + PW'(1'b1);
      2'b01:   pkt_cnt_d = pkt_cnt_q - PW'(1'b1);
      default: pkt_cnt_d = pkt_cnt_q;
    endcase
  end
`endif

  // Flags and outputs are computed from the next pointers, so the registered
  // ports reflect the new occupancy on the edge that changes it.
  always_comb begin
    empty_s   = (wr_ptr_d == rd_ptr_d);
    full_s    = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    count_d   = wr_ptr_d - rd_ptr_d;
    s_ready_d = !full_s;
`ifdef NASTI_STREAM_FIFO_PACKET_MODE_EN
    m_valid_d = !empty_s && ((pkt_cnt_d != {PW{1'b0}}) || full_s);
`else
    m_valid_d = !empty_s;
`endif
  end

  // State registers; reset forces ready low until the first edge after release.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q  <= {PW{1'b0}};
      rd_ptr_q  <= {PW{1'b0}};
      count_q   <= {PW{1'b0}};
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
    end
  end

`ifdef NASTI_STREAM_FIFO_PACKET_MODE_EN
  // Packet counter register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pkt_cnt_q <= {PW{1'b0}};
    end else begin
      pkt_cnt_q <= pkt_cnt_d;
    end
  end
`endif

  assign wr_entry_s = {s.t_data, s.t_strb, s.t_keep, s.t_last,
                       s.t_id, s.t_dest, s.t_user};

  nasti_stream_fifo_mem #(
    .EW    (EW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (push_s),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (wr_entry_s),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (rd_entry_s)
  );

  assign m.t_valid = m_valid_q;
  assign m.t_data  = rd_entry_s[OFF_DATA +: DATA_WIDTH];
  assign m.t_strb  = rd_entry_s[OFF_STRB +: SW];
  assign m.t_keep  = rd_entry_s[OFF_KEEP +: SW];
  assign m.t_last  = rd_entry_s[OFF_LAST];
  assign m.t_id    = rd_entry_s[OFF_ID +: ID_WIDTH];
  assign m.t_dest  = rd_entry_s[OFF_DEST +: DEST_WIDTH];
  assign m.t_user  = rd_entry_s[0 +: USER_WIDTH];

  assign s.t_ready = s_ready_q;
  assign count     = count_q;

endmodule

// File: tb/tb_nasti_stream_fifo.sv
module tb_nasti_stream_fifo;

  localparam int ID_W    = 2;
  localparam int DEST_W  = 2;
  localparam int USER_W  = 2;
  localparam int DATA_W  = 32;
  localparam int DEPTH   = 4;

  logic       clk  = 1'b0;
  logic       rstn = 1'b0;
  logic [2:0] count;
  int         n_cmp = 0;
  int         n_err = 0;

  nasti_stream_channel #(.ID_WIDTH(ID_W), .DEST_WIDTH(DEST_W),
                         .USER_WIDTH(USER_W), .DATA_WIDTH(DATA_W)) s_if ();
  nasti_stream_channel #(.ID_WIDTH(ID_W), .DEST_WIDTH(DEST_W),
                         .USER_WIDTH(USER_W), .DATA_WIDTH(DATA_W)) m_if ();

  nasti_stream_fifo #(
    .ID_WIDTH(ID_W), .DEST_WIDTH(DEST_W), .USER_WIDTH(USER_W),
    .DATA_WIDTH(DATA_W), .DEPTH(DEPTH)
  ) dut (
    .clk   (clk),
    .rstn  (rstn),
    .s     (s_if),
    .m     (m_if),
    .count (count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    s_if.t_valid = 1'b0;
    s_if.t_data  = 32'h0;
    s_if.t_strb  = 4'h0;
    s_if.t_keep  = 4'h0;
    s_if.t_last  = 1'b0;
    s_if.t_id    = 2'd0;
    s_if.t_dest  = 2'd0;
    s_if.t_user  = 2'd0;
  endtask

  task automatic drive_beat(input logic [31:0] d, input logic last);
    s_if.t_valid = 1'b1;
    s_if.t_data  = d;
    s_if.t_strb  = 4'hF;
    s_if.t_keep  = 4'hF;
    s_if.t_last  = last;
    s_if.t_id    = d[1:0];
    s_if.t_dest  = d[3:2];
    s_if.t_user  = d[5:4];
  endtask

  task automatic test_reset();
    #2;
    n_cmp++; if (s_if.t_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", s_if.t_ready); end
    n_cmp++; if (m_if.t_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", m_if.t_valid); end
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", count); end
    tick();
    n_cmp++; if (s_if.t_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready_held: got %b want 0", s_if.t_ready); end
    rstn = 1'b1;
    #1;
    n_cmp++; if (s_if.t_ready !== 1'b0) begin n_err++; $display("FAIL release_ready_pre_edge: got %b want 0", s_if.t_ready); end
    tick();
    n_cmp++; if (s_if.t_ready !== 1'b1) begin n_err++; $display("FAIL release_ready: got %b want 1", s_if.t_ready); end
    n_cmp++; if (m_if.t_valid !== 1'b0) begin n_err++; $display("FAIL release_valid: got %b want 0", m_if.t_valid); end
  endtask

  task automatic test_single();
    drive_beat(32'hDEADBEEF, 1'b1);
    s_if.t_id   = 2'd1;
    s_if.t_dest = 2'd2;
    s_if.t_user = 2'd3;
    s_if.t_keep = 4'hA;
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL single_count0: got %0d want 0", count); end
    tick();
    drive_idle();
    n_cmp++; if (m_if.t_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b want 1", m_if.t_valid); end
    n_cmp++; if (m_if.t_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_data: got %h want deadbeef", m_if.t_data); end
    n_cmp++; if (m_if.t_strb !== 4'hF) begin n_err++; $display("FAIL single_strb: got %h want f", m_if.t_strb); end
    n_cmp++; if (m_if.t_keep !== 4'hA) begin n_err++; $display("FAIL single_keep: got %h want a", m_if.t_keep); end
    n_cmp++; if (m_if.t_last !== 1'b1) begin n_err++; $display("FAIL single_last: got %b want 1", m_if.t_last); end
    n_cmp++; if (m_if.t_id !== 2'd1) begin n_err++; $display("FAIL single_id: got %0d want 1", m_if.t_id); end
    n_cmp++; if (m_if.t_dest !== 2'd2) begin n_err++; $display("FAIL single_dest: got %0d want 2", m_if.t_dest); end
    n_cmp++; if (m_if.t_user !== 2'd3) begin n_err++; $display("FAIL single_user: got %0d want 3", m_if.t_user); end
    n_cmp++; if (count !== 3'd1) begin n_err++; $display("FAIL single_count1: got %0d want 1", count); end
    m_if.t_ready = 1'b1;
    tick();
    m_if.t_ready = 1'b0;
    n_cmp++; if (m_if.t_valid !== 1'b0) begin n_err++; $display("FAIL single_valid_after: got %b want 0", m_if.t_valid); end
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL single_count_after: got %0d want 0", count); end
  endtask

  task automatic test_fill();
    int  exp;
    logic fs, fm;
    m_if.t_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      drive_beat(32'(i), 1'b1);
      tick();
    end
    n_cmp++; if (s_if.t_ready !== 1'b0) begin n_err++; $display("FAIL fill_ready_full: got %b want 0", s_if.t_ready); end
    n_cmp++; if (count !== 3'd4) begin n_err++; $display("FAIL fill_count_full: got %0d want 4", count); end
    drive_beat(32'd5, 1'b1);
    tick();
    tick();
    n_cmp++; if (count !== 3'd4) begin n_err++; $display("FAIL fill_fifth_held: got %0d want 4", count); end
    m_if.t_ready = 1'b1;
    exp = 1;
    for (int cyc = 0; cyc < 20 && exp <= 5; cyc++) begin
      fs = s_if.t_valid & s_if.t_ready;
      fm = m_if.t_valid & m_if.t_ready;
      if (fm) begin
        n_cmp++; if (m_if.t_data !== 32'(exp)) begin n_err++; $display("FAIL fill_order: got %0d want %0d", m_if.t_data, exp); end
        exp++;
      end
      tick();
      if (fs) drive_idle();
      if (cyc == 0) begin
        n_cmp++; if (count !== 3'd3) begin n_err++; $display("FAIL fill_pop_no_push: got %0d want 3", count); end
        n_cmp++; if (s_if.t_ready !== 1'b1) begin n_err++; $display("FAIL fill_ready_after_pop: got %b want 1", s_if.t_ready); end
      end
    end
    n_cmp++; if (exp !== 6) begin n_err++; $display("FAIL fill_drain_timeout: got %0d beats want 5", exp - 1); end
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL fill_count_end: got %0d want 0", count); end
    m_if.t_ready = 1'b0;
    drive_idle();
  endtask

  task automatic test_back_to_back();
    m_if.t_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      drive_beat(32'h1000 + 32'(i), 1'b1);
      tick();
      n_cmp++; if (count !== 3'd1) begin n_err++; $display("FAIL b2b_count[%0d]: got %0d want 1", i, count); end
      n_cmp++; if (m_if.t_data !== 32'h1000 + 32'(i)) begin n_err++; $display("FAIL b2b_data[%0d]: got %h want %h", i, m_if.t_data, 32'h1000 + 32'(i)); end
    end
    drive_idle();
    tick();
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL b2b_count_end: got %0d want 0", count); end
    n_cmp++; if (m_if.t_valid !== 1'b0) begin n_err++; $display("FAIL b2b_valid_end: got %b want 0", m_if.t_valid); end
    m_if.t_ready = 1'b0;
  endtask

  task automatic test_stall();
    logic [47:0] vld_pat;
    logic [47:0] rdy_pat;
    logic [31:0] sb[$];
    logic [31:0] nv;
    logic [31:0] sdat;
    logic fs, fm, stall_prev;
    vld_pat = 48'hF3B7_6DDE_FBEF;
    rdy_pat = 48'h8E38_E38E_38E3;
    nv = 32'h2000;
    stall_prev = 1'b0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (cyc < 48) begin
        m_if.t_ready = rdy_pat[cyc];
        if (!s_if.t_valid && vld_pat[cyc]) drive_beat(nv, 1'b1);
      end else begin
        m_if.t_ready = 1'b1;
      end
      if (stall_prev) begin
        n_cmp++; if (m_if.t_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid_drop[%0d]: got %b want 1", cyc, m_if.t_valid); end
      end
      if (m_if.t_valid === 1'b1) begin
        n_cmp++;
        if (sb.size() == 0) begin n_err++; $display("FAIL stall_spurious[%0d]: got valid want empty", cyc); end
        else if (m_if.t_data !== sb[0]) begin n_err++; $display("FAIL stall_data[%0d]: got %h want %h", cyc, m_if.t_data, sb[0]); end
      end
      fs = s_if.t_valid & s_if.t_ready;
      fm = m_if.t_valid & m_if.t_ready;
      sdat = s_if.t_data;
      stall_prev = m_if.t_valid & !m_if.t_ready;
      tick();
      if (fm && sb.size() > 0) void'(sb.pop_front());
      if (fs) begin
        sb.push_back(sdat);
        nv = nv + 32'd1;
        drive_idle();
      end
      n_cmp++; if (count !== 3'(sb.size())) begin n_err++; $display("FAIL stall_count[%0d]: got %0d want %0d", cyc, count, sb.size()); end
    end
    n_cmp++; if (sb.size() != 0) begin n_err++; $display("FAIL stall_drain: got %0d left want 0", sb.size()); end
    n_cmp++; if (nv < 32'h2008) begin n_err++; $display("FAIL stall_throughput: got %0d beats want >= 8", nv - 32'h2000); end
    m_if.t_ready = 1'b0;
    drive_idle();
  endtask

  task automatic test_midstream_reset();
    m_if.t_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_beat(32'h31 + 32'(i), 1'b1);
      tick();
    end
    drive_idle();
    n_cmp++; if (count !== 3'd3) begin n_err++; $display("FAIL rst_mid_count_pre: got %0d want 3", count); end
    #2;
    rstn = 1'b0;
    #1;
    n_cmp++; if (m_if.t_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_valid: got %b want 0", m_if.t_valid); end
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL rst_mid_count: got %0d want 0", count); end
    n_cmp++; if (s_if.t_ready !== 1'b0) begin n_err++; $display("FAIL rst_mid_ready: got %b want 0", s_if.t_ready); end
    tick();
    tick();
    rstn = 1'b1;
    tick();
    n_cmp++; if (s_if.t_ready !== 1'b1) begin n_err++; $display("FAIL rst_mid_ready_after: got %b want 1", s_if.t_ready); end
    drive_beat(32'hA5, 1'b1);
    tick();
    drive_idle();
    n_cmp++; if (m_if.t_valid !== 1'b1) begin n_err++; $display("FAIL rst_mid_new_valid: got %b want 1", m_if.t_valid); end
    n_cmp++; if (m_if.t_data !== 32'hA5) begin n_err++; $display("FAIL rst_mid_new_data: got %h want a5", m_if.t_data); end
    n_cmp++; if (count !== 3'd1) begin n_err++; $display("FAIL rst_mid_new_count: got %0d want 1", count); end
    m_if.t_ready = 1'b1;
    tick();
    m_if.t_ready = 1'b0;
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL rst_mid_end_count: got %0d want 0", count); end
  endtask

`ifdef NASTI_STREAM_FIFO_PACKET_MODE_EN
  task automatic test_packet_hold();
    m_if.t_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_beat(32'h40 + 32'(i), (i == 2));
      tick();
      if (i < 2) begin
        n_cmp++; if (m_if.t_valid !== 1'b0) begin n_err++; $display("FAIL pkt_hold_valid[%0d]: got %b want 0", i, m_if.t_valid); end
      end else begin
        n_cmp++; if (m_if.t_valid !== 1'b1) begin n_err++; $display("FAIL pkt_release_valid: got %b want 1", m_if.t_valid); end
      end
    end
    drive_idle();
    m_if.t_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (m_if.t_data !== 32'h40 + 32'(i)) begin n_err++; $display("FAIL pkt_hold_data[%0d]: got %h want %h", i, m_if.t_data, 32'h40 + 32'(i)); end
      tick();
    end
    m_if.t_ready = 1'b0;
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL pkt_hold_count_end: got %0d want 0", count); end
  endtask

  task automatic test_packet_long();
    int idx, rx;
    logic fs, fm, seen;
    idx = 0; rx = 0; seen = 1'b0;
    m_if.t_ready = 1'b1;
    for (int cyc = 0; cyc < 60 && rx < 6; cyc++) begin
      if (idx < 6) drive_beat(32'h60 + 32'(idx), (idx == 5));
      else drive_idle();
      if (m_if.t_valid === 1'b1 && !seen) begin
        seen = 1'b1;
        n_cmp++; if (count !== 3'd4) begin n_err++; $display("FAIL pkt_long_first_valid_count: got %0d want 4", count); end
      end
      fs = s_if.t_valid & s_if.t_ready;
      fm = m_if.t_valid & m_if.t_ready;
      if (fm) begin
        n_cmp++; if (m_if.t_data !== 32'h60 + 32'(rx)) begin n_err++; $display("FAIL pkt_long_data[%0d]: got %h want %h", rx, m_if.t_data, 32'h60 + 32'(rx)); end
        rx++;
      end
      tick();
      if (fs) idx++;
    end
    drive_idle();
    n_cmp++; if (rx !== 6) begin n_err++; $display("FAIL pkt_long_timeout: got %0d beats want 6", rx); end
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL pkt_long_count_end: got %0d want 0", count); end
    m_if.t_ready = 1'b0;
  endtask
`else
  task automatic test_cut_through();
    m_if.t_ready = 1'b0;
    drive_beat(32'h50, 1'b0);
    tick();
    drive_idle();
    n_cmp++; if (m_if.t_valid !== 1'b1) begin n_err++; $display("FAIL cut_valid: got %b want 1", m_if.t_valid); end
    n_cmp++; if (m_if.t_data !== 32'h50) begin n_err++; $display("FAIL cut_data: got %h want 50", m_if.t_data); end
    n_cmp++; if (m_if.t_last !== 1'b0) begin n_err++; $display("FAIL cut_last: got %b want 0", m_if.t_last); end
    m_if.t_ready = 1'b1;
    tick();
    m_if.t_ready = 1'b0;
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL cut_count_end: got %0d want 0", count); end
  endtask
`endif

  initial begin
    drive_idle();
    m_if.t_ready = 1'b0;
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_stall();
    test_midstream_reset();
`ifdef NASTI_STREAM_FIFO_PACKET_MODE_EN
    test_packet_hold();
    test_packet_long();
`else
    test_cut_through();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
